uart_crc_receiver: RTL and testbench

//  Serial receiver at the far end of the CRC-16 UART link; consumes the 26-bit frame produced by uart_transmitter.

---
 rtl/uart_crc_receiver.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_crc_receiver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_crc_receiver.sv
// uart_crc_receiver
// Receives the 26-bit CRC-16 UART frame: start(0), data[7:0] LSB-first,
// crc[15:0] LSB-first, stop(1). Recomputes CRC-16 (MSB-first, non-reflected,
// preset CRC_INIT, no final XOR) over the data byte. Presents one result per
// frame with a 1-cycle rx_valid strobe.
//
// Back-to-back frames: CHECK+DONE can outlast the half stop bit that remains
// after the stop sample, so the next start edge may arrive before the FSM is
// back in IDLE. A falling edge seen during CHECK/DONE is remembered together
// with its age. IDLE then enters START with the baud counter already advanced
// by that age, which keeps the mid-bit sampling grid aligned to the real edge.
// Edges seen before the stop sample (low stop bit, line held low) are never
// remembered, so a held-low line still needs a fresh high-to-low transition.
module uart_crc_receiver #(
    parameter int          CLK_FREQ  = 50000000,
    parameter int          BAUD_RATE = 9600,
    parameter logic [15:0] CRC_POLY  = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_in,
    output logic [7:0]  data_out,
    output logic [15:0] crc_rx,
    output logic [15:0] crc_calc,
    output logic        crc_ok,
    output logic        frame_err,
    output logic        rx_valid,
    output logic        rx_busy,
    output logic [7:0]  crc_err_count
);

    localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] DIV_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // One CRC-16 step for a single message bit, MSB-first.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, rx_prev_q;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;
    logic [15:0] crc_q, crc_d;
    logic        ferr_q, ferr_d;
    logic        pend_q, pend_d;
    logic [15:0] pend_cnt_q, pend_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [15:0] crc_rx_q, crc_rx_d;
    logic [15:0] crc_calc_q, crc_calc_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_busy_q;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic rx_s;
    logic fall_s;
    logic match_s;

    assign rx_s    = sync2_q;
    assign fall_s  = rx_prev_q & ~rx_s;
    assign match_s = (crc_q == crc_rx_q) && !ferr_q;

    // Two-flop synchroniser for the asynchronous line plus edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= rx_in;
            sync2_q   <= sync1_q;
            rx_prev_q <= sync2_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 5'd0;
            shift_q     <= 24'd0;
            crc_q       <= 16'd0;
            ferr_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_cnt_q  <= 16'd0;
            data_out_q  <= 8'd0;
            crc_rx_q    <= 16'd0;
            crc_calc_q  <= 16'd0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_busy_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            ferr_q      <= ferr_d;
            pend_q      <= pend_d;
            pend_cnt_q  <= pend_cnt_d;
            data_out_q  <= data_out_d;
            crc_rx_q    <= crc_rx_d;
            crc_calc_q  <= crc_calc_d;
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
            rx_valid_q  <= rx_valid_d;
            rx_busy_q   <= (state_d != S_IDLE);
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state and datapath decisions for the frame FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        ferr_d      = ferr_q;
        pend_d      = pend_q;
        pend_cnt_d  = pend_q ? (pend_cnt_q + 16'd1) : pend_cnt_q;
        data_out_d  = data_out_q;
        crc_rx_d    = crc_rx_q;
        crc_calc_d  = crc_calc_q;
        crc_ok_d    = crc_ok_q;
        frame_err_d = frame_err_q;
        rx_valid_d  = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                pend_d = 1'b0;
                if (fall_s) begin
                    state_d = S_START;
                    cnt_d   = 16'd0;
                end else if (pend_q && !rx_s) begin
                    // Resume an edge caught during CHECK/DONE at its true age.
                    state_d = S_START;
                    cnt_d   = pend_cnt_q + 16'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q >= HALF_LAST) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = S_DATA;
                        // Carry any late-entry overshoot so data samples stay mid-bit.
                        cnt_d   = cnt_q - HALF_LAST;
                        idx_d   = 5'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q >= DIV_LAST) begin
                    shift_d = {rx_s, shift_q[23:1]};
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 5'd1;
                    if (idx_q == 5'd23) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q >= DIV_LAST) begin
                    ferr_d     = ~rx_s;
                    data_out_d = shift_q[7:0];
                    crc_rx_d   = shift_q[23:8];
                    crc_d      = CRC_INIT;
                    idx_d      = 5'd0;
                    cnt_d      = 16'd0;
                    state_d    = S_CHECK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_CHECK: begin
                crc_d = crc_step(crc_q, data_out_q[3'd7 - idx_q[2:0]]);
                idx_d = idx_q + 5'd1;
                if (idx_q == 5'd7) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CHECK;
                end
                if (fall_s) begin
                    pend_d     = 1'b1;
                    pend_cnt_d = 16'd0;
                end else begin
                    pend_d = pend_q;
                end
            end
            S_DONE: begin
                crc_calc_d  = crc_q;
                crc_ok_d    = match_s;
                frame_err_d = ferr_q;
                rx_valid_d  = 1'b1;
                if (!match_s && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    err_cnt_d = err_cnt_q;
                end
                if (fall_s) begin
                    pend_d     = 1'b1;
                    pend_cnt_d = 16'd0;
                end else begin
                    pend_d = pend_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign data_out      = data_out_q;
    assign crc_rx        = crc_rx_q;
    assign crc_calc      = crc_calc_q;
    assign crc_ok        = crc_ok_q;
    assign frame_err     = frame_err_q;
    assign rx_valid      = rx_valid_q;
    assign rx_busy       = rx_busy_q;
    assign crc_err_count = err_cnt_q;

endmodule

// File: tb/tb_uart_crc_receiver.sv
// tb_uart_crc_receiver
// Directed bench: a bit-level line driver sends hand-built frames. A negedge
// monitor captures every rx_valid strobe. Expected CRCs are hand-computed
// CRC-16 values with preset FFFF: 00->E1F0, 01->F1D1, 80->7078, FF->FF00.
module tb_uart_crc_receiver;

    localparam int BIT = 10;

    logic        clk;
    logic        reset;
    logic        rx_in;
    logic [7:0]  data_out;
    logic [15:0] crc_rx;
    logic [15:0] crc_calc;
    logic        crc_ok;
    logic        frame_err;
    logic        rx_valid;
    logic        rx_busy;
    logic [7:0]  crc_err_count;

    int errors = 0;
    int checks = 0;

    int          strobes = 0;
    logic [7:0]  m_data;
    logic [15:0] m_crx;
    logic [15:0] m_ccalc;
    logic        m_ok;
    logic        m_ferr;
    logic [7:0]  m_cnt;

    uart_crc_receiver #(
        .CLK_FREQ (1000000),
        .BAUD_RATE(100000),
        .CRC_POLY (16'h1021),
        .CRC_INIT (16'hFFFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .data_out     (data_out),
        .crc_rx       (crc_rx),
        .crc_calc     (crc_calc),
        .crc_ok       (crc_ok),
        .frame_err    (frame_err),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .crc_err_count(crc_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture each result strobe away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            strobes = strobes + 1;
            m_data  = data_out;
            m_crx   = crc_rx;
            m_ccalc = crc_calc;
            m_ok    = crc_ok;
            m_ferr  = frame_err;
            m_cnt   = crc_err_count;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [25:0] make_frame(input logic [7:0] d, input logic [15:0] c, input logic stop);
        return {stop, c, d, 1'b0};
    endfunction

    // Drive the first n bits of a frame, one bit period each, starting at a negedge.
    task automatic drive_bits(input logic [25:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            rx_in = f[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [15:0] c, input logic stop);
        drive_bits(make_frame(d, c, stop), 26);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for the strobe counter to reach a target; a timeout shows as a mismatch.
    task automatic wait_strobes(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (strobes < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_val(tag, strobes, target);
    endtask

    task automatic check_result(input string tag, input logic [7:0] d, input logic [15:0] crx,
                                input logic [15:0] ccalc, input logic ok, input logic ferr,
                                input logic [7:0] cnt);
        check_val({tag, "_data"}, m_data, d);
        check_val({tag, "_crc_rx"}, m_crx, crx);
        check_val({tag, "_crc_calc"}, m_ccalc, ccalc);
        check_val({tag, "_ok_ferr"}, {m_ok, m_ferr}, {ok, ferr});
        check_val({tag, "_count"}, m_cnt, cnt);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_data", data_out, 8'h00);
        check_val("rst_crc", {crc_rx, crc_calc}, 32'h0);
        check_val("rst_flags", {crc_ok, frame_err, rx_valid, rx_busy}, 4'h0);
        check_val("rst_count", crc_err_count, 8'h00);
        reset = 1'b0;
        idle(20);

        // Good frame, data 00.
        send_frame(8'h00, 16'hE1F0, 1'b1);
        wait_strobes("t1_strobe", 1, 40);
        check_result("t1", 8'h00, 16'hE1F0, 16'hE1F0, 1'b1, 1'b0, 8'd0);
        idle(40);
        check_val("t1_single", strobes, 1);
        check_val("t1_idle_busy", rx_busy, 1'b0);

        // Corrupted CRC field.
        send_frame(8'h00, 16'hE1F1, 1'b1);
        wait_strobes("t2_strobe", 2, 40);
        check_result("t2", 8'h00, 16'hE1F1, 16'hE1F0, 1'b0, 1'b0, 8'd1);
        idle(20);

        // More good frames over distinct data patterns.
        send_frame(8'h80, 16'h7078, 1'b1);
        wait_strobes("t2b_strobe", 3, 40);
        check_result("t2b", 8'h80, 16'h7078, 16'h7078, 1'b1, 1'b0, 8'd1);
        idle(20);
        send_frame(8'h01, 16'hF1D1, 1'b1);
        wait_strobes("t2c_strobe", 4, 40);
        check_result("t2c", 8'h01, 16'hF1D1, 16'hF1D1, 1'b1, 1'b0, 8'd1);
        idle(20);

        // Stop bit low, then line held low: one strobe only.
        send_frame(8'h00, 16'hE1F0, 1'b0);
        wait_strobes("t3_strobe", 5, 40);
        check_result("t3", 8'h00, 16'hE1F0, 16'hE1F0, 1'b0, 1'b1, 8'd2);
        repeat (60) @(negedge clk);
        idle(60);
        check_val("t3_no_second", strobes, 5);
        send_frame(8'hFF, 16'hFF00, 1'b1);
        wait_strobes("t3b_strobe", 6, 40);
        check_result("t3b", 8'hFF, 16'hFF00, 16'hFF00, 1'b1, 1'b0, 8'd2);
        idle(30);

        // 3-clock low glitch in IDLE is rejected by START.
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        @(negedge clk);
        check_val("t4_busy_start", rx_busy, 1'b1);
        repeat (7) @(negedge clk);
        check_val("t4_busy_back", rx_busy, 1'b0);
        idle(40);
        check_val("t4_no_strobe", strobes, 6);

        // Reset during DATA bit 12.
        drive_bits(make_frame(8'h55, 16'h1234, 1'b1), 13);
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        check_val("t5_busy_pre", rx_busy, 1'b1);
        reset = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        check_val("t5_rst_data", data_out, 8'h00);
        check_val("t5_rst_crc", {crc_rx, crc_calc}, 32'h0);
        check_val("t5_rst_flags", {crc_ok, frame_err, rx_valid, rx_busy}, 4'h0);
        check_val("t5_rst_count", crc_err_count, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(40);
        check_val("t5_no_strobe", strobes, 6);
        send_frame(8'h80, 16'h7078, 1'b1);
        wait_strobes("t5_strobe", 7, 40);
        check_result("t5", 8'h80, 16'h7078, 16'h7078, 1'b1, 1'b0, 8'd0);
        idle(20);

        // 300 back-to-back bad-CRC frames: every one decoded, counter saturates.
        base = strobes;
        for (int n = 0; n < 300; n++) begin
            send_frame(8'hFF, 16'h0000, 1'b1);
        end
        wait_strobes("t6_strobes", base + 300, 60);
        check_result("t6", 8'hFF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 8'hFF);
        idle(40);
        check_val("t6_count_hold", crc_err_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
